ram_72x8_master: RTL and testbench
==================================

Name: ram_72x8_master

Overview:
- Initiator for the 72-bit x 8-word DFF RAM (active-low enable/write, 3-bit address).
- Accepts burst read/write requests from a client over valid/ready handshakes.
- Generates the RAM command sequence with address auto-increment.
- Returns read data through a one-entry, backpressurable response register.

Parameters:
- DATA_W, 72, RAM word width.
- ADDR_W, 3, RAM address width; depth = 2**ADDR_W.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  client request valid.
- req_ready  output  1  master accepts request (IDLE only).
- req_wr  input  1  1 = write burst, 0 = read burst.
- req_addr  input  ADDR_W  burst start address.
- req_len  input  ADDR_W  beats minus one (0..7).
- wdata_valid  input  1  write beat valid.
- wdata_ready  output  1  write beat accepted.
- wdata  input  DATA_W  write beat data.
- rsp_valid  output  1  read response valid.
- rsp_ready  input  1  client accepts response.
- rsp_data  output  DATA_W  read data.
- rsp_last  output  1  marks final beat of read burst.
- wr_done  output  1  one-cycle pulse after final write beat.
- ram_en_n  output  1  RAM enable, active low.
- ram_wr_n  output  1  RAM write, active low.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - ram_en_n=1, ram_wr_n=1, ram_addr=0, ram_din=0.
  - rsp_valid=0, rsp_data=0, rsp_last=0, wr_done=0, wdata_ready=0.
  - req_ready=1 once reset is released.
- RAM timing:
  - The RAM samples commands on the rising edge.
  - Read data is valid on ram_dout during the cycle after the command cycle.
  - The master captures ram_dout into rsp_data at the end of that cycle, so rsp_valid rises 2 cycles after the command.
- States: IDLE, WRITE, READ, WAIT_RSP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr and len, clear the beat counter, then go to WRITE (req_wr=1) or READ (req_wr=0).
  - RAM outputs are idle (en_n=1, wr_n=1).
- WRITE:
  - wdata_ready=1.
  - In each cycle with wdata_valid=1: ram_en_n=0, ram_wr_n=0, ram_addr=current addr, ram_din=wdata.
  - On each such beat, addr increments mod 8 and the counter increments.
  - On the beat where counter==len: go to IDLE and pulse wr_done in the next cycle.
  - wdata_valid=0 stalls the burst with no RAM command issued.
- READ:
  - A read command issues only when no read is in flight and the response register is free (rsp_valid=0, or rsp_valid&&rsp_ready this cycle).
  - Command: ram_en_n=0, ram_wr_n=1, ram_addr=current addr.
  - Sustained throughput is 1 beat per 2 cycles.
  - After the command for beat len issues, go to WAIT_RSP.
- WAIT_RSP: go to IDLE when the beat marked rsp_last is captured and then accepted (rsp_valid&&rsp_ready).
- Response register:
  - rsp_data, rsp_valid and rsp_last hold stable while rsp_valid && !rsp_ready.
  - Never overwritten while valid and unaccepted.
  - rsp_last=1 only with the beat whose index equals len.
- Address wrap: the increment from address 7 goes to 0 (e.g. start 6, len 3 visits 6, 7, 0, 1).
- Request handling:
  - req_valid outside IDLE is ignored; req_ready=0 there.
  - Request fields are sampled only at acceptance.
- ram_en_n is never 0 in IDLE or WAIT_RSP.
- ram_wr_n=0 only in WRITE together with ram_en_n=0.
- Reset mid-burst: the burst is abandoned, no further RAM commands are issued, and any pending response is dropped.

Test Plan:
- Reset: assert rst mid-cycle -> ram_en_n=1, ram_wr_n=1, rsp_valid=0 and req_ready=1 after release, all without waiting for a clock edge.
- Single write/read:
  - Write addr 5, len 0, data 72'hA5...A5 -> one cycle with en_n=0, wr_n=0, addr 5; wr_done pulses.
  - Then read addr 5 -> rsp_data=72'hA5...A5 with rsp_last=1, rsp_valid rising 2 cycles after the command.
- Wrapping burst:
  - Write addr 6, len 3, data 1..4 -> RAM addresses 6, 7, 0, 1.
  - Read back addr 6, len 3 -> responses 1, 2, 3, 4; rsp_last only on 4.
- Backpressure:
  - Read len 7 with rsp_ready held 0 for 5 cycles after the first response -> rsp_data stable and no new read command in that window.
  - All 8 beats arrive in order.
- Write stall: wdata_valid toggled 1, 0, 0, 1 during a len-1 write -> exactly 2 RAM write commands, on the valid cycles only.
- Busy/abort:
  - req_valid during a read burst -> ignored, req_ready=0.
  - rst asserted during beat 3 of 8 -> no further commands; IDLE after release.

Source files
------------

// File: rtl/ram_72x8_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_72x8_master
// Purpose  : Burst read/write initiator for a 72x8 DFF RAM with a
//            backpressurable one-entry read response register.
// Revision : 1.0
// ============================================================================
module ram_72x8_master #(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              ram_en_n,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_READ     = 2'd2,
    S_WAIT_RSP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rd_inflight;
  logic              r_rd_inflight_last;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic              r_wr_done;

  logic w_accept;
  logic w_wr_beat;
  logic w_rd_cmd;
  logic w_rsp_free;
  logic w_last_beat;

  // Response slot is free if empty or being drained this cycle.
  assign w_rsp_free  = !r_rsp_valid || rsp_ready;
  assign w_last_beat = (r_cnt == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_wr_beat   = 1'b0;
    w_rd_cmd    = 1'b0;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    ram_en_n    = 1'b1;
    ram_wr_n    = 1'b1;
    ram_addr    = '0;
    ram_din     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = req_wr ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          w_wr_beat = 1'b1;
          ram_en_n  = 1'b0;
          ram_wr_n  = 1'b0;
          ram_addr  = r_addr;
          ram_din   = wdata;
          if (w_last_beat) w_next = S_IDLE;
        end
      end
      S_READ: begin
        // One read outstanding at a time keeps the response slot single-entry.
        if (!r_rd_inflight && w_rsp_free) begin
          w_rd_cmd = 1'b1;
          ram_en_n = 1'b0;
          ram_addr = r_addr;
          if (w_last_beat) w_next = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (r_rsp_valid && rsp_ready && r_rsp_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr             <= '0;
      r_len              <= '0;
      r_cnt              <= '0;
      r_rd_inflight      <= 1'b0;
      r_rd_inflight_last <= 1'b0;
      r_rsp_data         <= '0;
      r_rsp_valid        <= 1'b0;
      r_rsp_last         <= 1'b0;
      r_wr_done          <= 1'b0;
    end else begin
      r_wr_done          <= w_wr_beat && w_last_beat;
      r_rd_inflight      <= w_rd_cmd;
      r_rd_inflight_last <= w_rd_cmd && w_last_beat;
      if (w_accept) begin
        r_addr <= req_addr;
        r_len  <= req_len;
        r_cnt  <= '0;
      end else if (w_wr_beat || w_rd_cmd) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
      // Capture is unconditional: a read only issues when the slot will be free.
      if (r_rd_inflight) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= ram_dout;
        r_rsp_last  <= r_rd_inflight_last;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rsp_last  <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign wr_done   = r_wr_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_72x8_master.sv
`default_nettype none
// Testbench for ram_72x8_master: RAM model plus an array-based memory
// reference; randomized bursts, stalls, backpressure and reset abort.
module tb_ram_72x8_master;
  localparam int DATA_W = 72;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  typedef logic [DATA_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [ADDR_W-1:0] req_len = '0;
  logic              wdata_valid = 1'b0;
  logic              wdata_ready;
  word_t             wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  word_t             rsp_data;
  logic              rsp_last;
  logic              wr_done;
  logic              ram_en_n;
  logic              ram_wr_n;
  logic [ADDR_W-1:0] ram_addr;
  word_t             ram_din;
  word_t             ram_dout = '0;

  int n_checks = 0;
  int n_errors = 0;

  word_t ram_mem [DEPTH];
  word_t exp_mem [DEPTH];

  ram_72x8_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .wr_done(wr_done),
    .ram_en_n(ram_en_n), .ram_wr_n(ram_wr_n), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // DFF RAM: read data appears in the cycle after the command.
  always @(posedge clk) begin
    if (!ram_en_n) begin
      if (!ram_wr_n) ram_mem[ram_addr] <= ram_din;
      else           ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic check_val(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a, input int i);
    return ADDR_W'((int'(a) + i) % DEPTH);
  endfunction

  // mode: 0 no stall, 1 random stall, 2 valid pattern 1,0,0,1
  // dkind: 0 random, 1 all A5, 2 beat index + 1
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len,
                          input int mode, input int dkind);
    word_t beats [DEPTH];
    int    i;
    int    t;
    logic  wv;
    for (int b = 0; b < DEPTH; b++) begin
      case (dkind)
        1:       beats[b] = {9{8'hA5}};
        2:       beats[b] = word_t'(b + 1);
        default: beats[b] = word_t'({$urandom, $urandom, $urandom});
      endcase
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_len = len;
    @(negedge clk);
    check_val("wr_req_ready_idle", word_t'(req_ready), word_t'(1'b1));
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ADDR_W'($urandom); req_len = ADDR_W'($urandom);
    i = 0;
    t = 0;
    while (i <= int'(len) && t < 100) begin
      case (mode)
        1:       wv = 1'($urandom_range(0, 1));
        2:       wv = (t == 0 || t == 3);
        default: wv = 1'b1;
      endcase
      wdata_valid = wv;
      wdata = wv ? beats[i] : word_t'({$urandom, $urandom, $urandom});
      @(negedge clk);
      check_val("wr_wdata_ready", word_t'(wdata_ready), word_t'(1'b1));
      check_val("wr_req_ready_busy", word_t'(req_ready), word_t'(1'b0));
      check_val("wr_done_early", word_t'(wr_done), word_t'(1'b0));
      check_val("wr_en_n", word_t'(ram_en_n), word_t'(!wv));
      if (wv) begin
        check_val("wr_wr_n", word_t'(ram_wr_n), word_t'(1'b0));
        check_val("wr_addr", word_t'(ram_addr), word_t'(beat_addr(a, i)));
        check_val("wr_din", ram_din, beats[i]);
        exp_mem[beat_addr(a, i)] = beats[i];
        i++;
      end else begin
        check_val("wr_stall_wr_n", word_t'(ram_wr_n), word_t'(1'b1));
      end
      @(posedge clk); #1;
      t++;
    end
    wdata_valid = 1'b0;
    if (t >= 100) check_val("wr_timeout", word_t'(t), word_t'(0));
    @(negedge clk);
    check_val("wr_done_pulse", word_t'(wr_done), word_t'(1'b1));
    check_val("wr_back_idle", word_t'(req_ready), word_t'(1'b1));
    check_val("wr_idle_en_n", word_t'(ram_en_n), word_t'(1'b1));
    @(negedge clk);
    check_val("wr_done_one_cycle", word_t'(wr_done), word_t'(1'b0));
  endtask

  // bp: 0 always ready, 1 random ready, 2 hold ready low 5 cycles past first response
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len, input int bp);
    int    k;
    int    cmds;
    int    t;
    int    last_cmd_t;
    int    hold;
    bit    seen;
    logic  prev_v;
    logic  prev_blocked;
    logic  prev_last;
    word_t prev_d;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_len = len;
    @(negedge clk);
    check_val("rd_req_ready_idle", word_t'(req_ready), word_t'(1'b1));
    @(posedge clk); #1;
    k = 0; cmds = 0; t = 0; last_cmd_t = -100; hold = 0; seen = 0;
    prev_v = 1'b0; prev_blocked = 1'b0; prev_last = 1'b0; prev_d = '0;
    while (k <= int'(len) && t < 200) begin
      case (bp)
        1: rsp_ready = 1'($urandom_range(0, 1));
        2: begin
          rsp_ready = seen && hold >= 5;
          if (seen && hold < 5) hold++;
        end
        default: rsp_ready = 1'b1;
      endcase
      // Stray requests while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_wr = 1'($urandom); req_addr = ADDR_W'($urandom); req_len = ADDR_W'($urandom);
      @(negedge clk);
      check_val("rd_req_ready_busy", word_t'(req_ready), word_t'(1'b0));
      if (rsp_valid && !prev_v)
        check_val("rd_latency", word_t'(t - last_cmd_t), word_t'(2));
      if (prev_blocked) begin
        check_val("rd_hold_valid", word_t'(rsp_valid), word_t'(1'b1));
        check_val("rd_hold_data", rsp_data, prev_d);
        check_val("rd_hold_last", word_t'(rsp_last), word_t'(prev_last));
      end
      if (rsp_valid && !rsp_ready)
        check_val("rd_no_cmd_when_full", word_t'(ram_en_n), word_t'(1'b1));
      if (!ram_en_n) begin
        check_val("rd_wr_n", word_t'(ram_wr_n), word_t'(1'b1));
        check_val("rd_addr", word_t'(ram_addr), word_t'(beat_addr(a, cmds)));
        check_val("rd_cmd_extra", word_t'(cmds <= int'(len)), word_t'(1'b1));
        cmds++;
        last_cmd_t = t;
      end
      if (rsp_valid) seen = 1;
      if (rsp_valid && rsp_ready) begin
        check_val("rd_data", rsp_data, exp_mem[beat_addr(a, k)]);
        check_val("rd_last", word_t'(rsp_last), word_t'(k == int'(len)));
        k++;
      end
      prev_v = rsp_valid;
      prev_blocked = rsp_valid && !rsp_ready;
      prev_d = rsp_data;
      prev_last = rsp_last;
      @(posedge clk); #1;
      t++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    if (t >= 200) check_val("rd_timeout", word_t'(t), word_t'(0));
    @(negedge clk);
    check_val("rd_cmd_count", word_t'(cmds), word_t'(int'(len) + 1));
    check_val("rd_back_idle", word_t'(req_ready), word_t'(1'b1));
    check_val("rd_idle_en_n", word_t'(ram_en_n), word_t'(1'b1));
    check_val("rd_rsp_drained", word_t'(rsp_valid), word_t'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab_cmds;
    int ab_t;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_en_n", word_t'(ram_en_n), word_t'(1'b1));
    check_val("rst_wr_n", word_t'(ram_wr_n), word_t'(1'b1));
    check_val("rst_addr", word_t'(ram_addr), word_t'(0));
    check_val("rst_din", ram_din, word_t'(0));
    check_val("rst_rsp_valid", word_t'(rsp_valid), word_t'(1'b0));
    check_val("rst_rsp_data", rsp_data, word_t'(0));
    check_val("rst_wr_done", word_t'(wr_done), word_t'(1'b0));
    check_val("rst_wdata_ready", word_t'(wdata_ready), word_t'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_req_ready", word_t'(req_ready), word_t'(1'b1));

    do_write(3'd0, 3'd7, 1, 0);
    do_write(3'd5, 3'd0, 0, 1);
    do_read (3'd5, 3'd0, 0);
    do_write(3'd6, 3'd3, 0, 2);
    do_read (3'd6, 3'd3, 0);
    do_read (3'd0, 3'd7, 2);
    do_write(ADDR_W'($urandom), 3'd1, 2, 0);
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(ADDR_W'($urandom), ADDR_W'($urandom), $urandom_range(0, 1), 0);
      else
        do_read(ADDR_W'($urandom), ADDR_W'($urandom), $urandom_range(0, 1));
    end

    // Abort a read burst with a mid-cycle reset on its third command.
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 3'd0; req_len = 3'd7; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ab_cmds = 0;
    ab_t = 0;
    while (ab_cmds < 3 && ab_t < 100) begin
      @(negedge clk);
      if (!ram_en_n) ab_cmds++;
      ab_t++;
    end
    if (ab_t >= 100) check_val("abort_timeout", word_t'(ab_t), word_t'(0));
    #2 rst = 1'b1;
    #1;
    check_val("abort_en_n", word_t'(ram_en_n), word_t'(1'b1));
    check_val("abort_wr_n", word_t'(ram_wr_n), word_t'(1'b1));
    check_val("abort_rsp_valid", word_t'(rsp_valid), word_t'(1'b0));
    repeat (2) begin
      @(negedge clk);
      check_val("abort_rst_en_n", word_t'(ram_en_n), word_t'(1'b1));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_val("abort_post_en_n", word_t'(ram_en_n), word_t'(1'b1));
      check_val("abort_post_rsp", word_t'(rsp_valid), word_t'(1'b0));
      check_val("abort_post_idle", word_t'(req_ready), word_t'(1'b1));
    end
    rsp_ready = 1'b0;

    do_read(3'd6, 3'd3, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
